// File: rtl/gecko_pkg.sv
// Shared gecko definitions: shift types, fill modes and bit helpers.
// GECKO_SHIFT_ROTATE_EN enables the rotate-left shift type.
package gecko_pkg;

   localparam int GECKO_MAX_WIDTH = 64;
   localparam int GECKO_MAX_SHAMT = 6;

   typedef enum logic [1:0] {
      GECKO_SHIFT_LL = 'h0,
      GECKO_SHIFT_RL = 'h1,
      GECKO_SHIFT_RA = 'h2,
      GECKO_SHIFT_RO = 'h3
   } gecko_shift_type_t;

   typedef enum logic [1:0] {
      GECKO_FILL_ZERO = 'h0,
      GECKO_FILL_ONES = 'h1,
      GECKO_FILL_ROT  = 'h2
   } gecko_fill_t;

   typedef enum logic [1:0] {
      GECKO_SH_IDLE = 'h0,
      GECKO_SH_BUSY = 'h1,
      GECKO_SH_DONE = 'h2
   } gecko_shift_state_t;

   function automatic logic [GECKO_MAX_WIDTH-1:0] gecko_reverse_bits(
      input logic [GECKO_MAX_WIDTH-1:0] v,
      input int                         w
   );
      logic [GECKO_MAX_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < GECKO_MAX_WIDTH; i++) begin
         if (i < w) r[i] = v[w-1-i];
      end
      return r;
   endfunction

   // Strides that would push every bit out of the amount field act as zero.
   function automatic logic [GECKO_MAX_SHAMT-1:0] gecko_get_effective_shift(
      input logic [GECKO_MAX_SHAMT-1:0] shift,
      input logic [2:0]                 stride,
      input int                         shamt_w
   );
      logic [GECKO_MAX_SHAMT-1:0] amt;
      int                         s;
      s   = (int'(stride) >= shamt_w) ? 0 : int'(stride);
      amt = shift << s;
      for (int i = 0; i < GECKO_MAX_SHAMT; i++) begin
         if (i >= shamt_w) amt[i] = 1'b0;
      end
      return amt;
   endfunction

endpackage

// File: rtl/gecko_shift_stage.sv
// One group step of the iterative shifter: left shift with selectable fill.
// Rotate fill exists only when GECKO_SHIFT_ROTATE_EN is defined.
module gecko_shift_stage
   import gecko_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int STAGE_BITS = 2,
   parameter int GROUPS     = 3,
   parameter int KW         = 2
) (
   input  logic [WIDTH-1:0]      i_value,
   input  logic [STAGE_BITS-1:0] i_group,
   input  logic [KW-1:0]         i_index,
   input  gecko_fill_t           i_fill,
   output logic [WIDTH-1:0]      o_value
);

   localparam int GW = GROUPS * STAGE_BITS;
   localparam int AW = GW + 1;

   logic [AW-1:0]    w_amt;
   logic [WIDTH-1:0] w_shl;
   logic [WIDTH-1:0] w_mask;

   assign w_amt  = AW'(i_group) << (32'(i_index) * STAGE_BITS);
   assign w_shl  = i_value << w_amt;
   assign w_mask = ~({WIDTH{1'b1}} << w_amt);

`ifdef GECKO_SHIFT_ROTATE_EN
   logic [WIDTH-1:0] w_wrap;
   // A zero amount shifts by WIDTH, which yields no wrapped bits.
   assign w_wrap = i_value >> (AW'(WIDTH) - w_amt);
`endif

   always_comb begin
      o_value = w_shl;
      case (i_fill)
         GECKO_FILL_ONES: o_value = w_shl | w_mask;
`ifdef GECKO_SHIFT_ROTATE_EN
         GECKO_FILL_ROT:  o_value = w_shl | w_wrap;
`endif
         default:         o_value = w_shl;
      endcase
   end

endmodule

// File: rtl/gecko_iterative_shifter.sv
// Multi-cycle shifter resolving STAGE_BITS amount bits per cycle.
// GECKO_SHIFT_ROTATE_EN enables cmd type 3 as rotate left (else LL).
module gecko_iterative_shifter
   import gecko_pkg::*;
#(
   parameter  int WIDTH       = 32,
   parameter  int STAGE_BITS  = 2,
   localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [WIDTH-1:0]       i_cmd_value,
   input  logic [1:0]             i_cmd_type,
   input  logic [SHAMT_WIDTH-1:0] i_cmd_shift,
   input  logic [2:0]             i_cmd_stride,
   output logic                   o_result_valid,
   input  logic                   i_result_ready,
   output logic [WIDTH-1:0]       o_result_value
);

   localparam int GROUPS = (SHAMT_WIDTH + STAGE_BITS - 1) / STAGE_BITS;
   localparam int GW     = GROUPS * STAGE_BITS;
   localparam int KW     = $clog2(GROUPS + 1);

   gecko_shift_state_t r_state, w_next_state;

   logic [WIDTH-1:0] r_value;
   logic [WIDTH-1:0] r_result;
   logic [GW-1:0]    r_rem;
   logic [KW-1:0]    r_k;
   gecko_fill_t      r_fill;
   logic             r_rev;

   gecko_shift_type_t     w_type;
   gecko_fill_t           w_fill;
   logic                  w_is_right;
   logic [SHAMT_WIDTH-1:0] w_eff;
   logic [WIDTH-1:0]      w_cmd_rev;
   logic [WIDTH-1:0]      w_stage;
   logic [WIDTH-1:0]      w_stage_rev;
   logic [STAGE_BITS-1:0] w_group;
   logic [GW-1:0]         w_rem_next;
   logic                  w_last;

   assign w_type     = gecko_shift_type_t'(i_cmd_type);
   assign w_is_right = (w_type == GECKO_SHIFT_RL) ||
                       (w_type == GECKO_SHIFT_RA);
   assign w_eff      = SHAMT_WIDTH'(gecko_get_effective_shift(
                          GECKO_MAX_SHAMT'(i_cmd_shift),
                          i_cmd_stride, SHAMT_WIDTH));
   assign w_cmd_rev  = WIDTH'(gecko_reverse_bits(
                          GECKO_MAX_WIDTH'(i_cmd_value), WIDTH));

   // Arithmetic right becomes a ones-fill left shift on the reversed word.
   always_comb begin
      w_fill = GECKO_FILL_ZERO;
      if (w_type == GECKO_SHIFT_RA && i_cmd_value[WIDTH-1])
         w_fill = GECKO_FILL_ONES;
`ifdef GECKO_SHIFT_ROTATE_EN
      if (w_type == GECKO_SHIFT_RO)
         w_fill = GECKO_FILL_ROT;
`endif
   end

   assign w_group    = r_rem[32'(r_k)*STAGE_BITS +: STAGE_BITS];
   assign w_rem_next = r_rem &
                       ~(GW'({STAGE_BITS{1'b1}}) << (32'(r_k) * STAGE_BITS));
   assign w_last     = (w_rem_next == '0) || (32'(r_k) + 1 == GROUPS);

   gecko_shift_stage #(
      .WIDTH      (WIDTH),
      .STAGE_BITS (STAGE_BITS),
      .GROUPS     (GROUPS),
      .KW         (KW)
   ) u_stage (
      .i_value (r_value),
      .i_group (w_group),
      .i_index (r_k),
      .i_fill  (r_fill),
      .o_value (w_stage)
   );

   assign w_stage_rev = WIDTH'(gecko_reverse_bits(
                           GECKO_MAX_WIDTH'(w_stage), WIDTH));

   always_comb begin
      w_next_state   = r_state;
      o_cmd_ready    = 1'b0;
      o_result_valid = 1'b0;
      case (r_state)
         GECKO_SH_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) w_next_state = GECKO_SH_BUSY;
         end
         GECKO_SH_BUSY: begin
            if (w_last) w_next_state = GECKO_SH_DONE;
         end
         GECKO_SH_DONE: begin
            o_result_valid = 1'b1;
            if (i_result_ready) w_next_state = GECKO_SH_IDLE;
         end
         default: w_next_state = GECKO_SH_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= GECKO_SH_IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_value  <= '0;
         r_result <= '0;
         r_rem    <= '0;
         r_k      <= '0;
         r_fill   <= GECKO_FILL_ZERO;
         r_rev    <= 1'b0;
      end else begin
         case (r_state)
            GECKO_SH_IDLE: begin
               if (i_cmd_valid) begin
                  r_value <= w_is_right ? w_cmd_rev : i_cmd_value;
                  r_rem   <= GW'(w_eff);
                  r_k     <= '0;
                  r_fill  <= w_fill;
                  r_rev   <= w_is_right;
               end
            end
            GECKO_SH_BUSY: begin
               r_value <= w_stage;
               r_rem   <= w_rem_next;
               if (w_last)
                  r_result <= r_rev ? w_stage_rev : w_stage;
               else
                  r_k <= r_k + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_result_value = r_result;

endmodule
